// File: rtl/bnn_pkg.sv
// Shared types and helpers for the time-multiplexed BNN layer.
// Holds the FSM state encoding, load-port select codes and width helpers.
package bnn_pkg;

  typedef enum logic [1:0] {IDLE, COMPUTE, HOLD} state_e;

  localparam logic LD_WEIGHT = 1'b0;
  localparam logic LD_THR    = 1'b1;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  // Pointer width that stays at least one bit for single-entry ranges.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bnn_layer_seq_if.sv
// Handshake bundle of one BNN layer: input vector, serial load port, result vector.
// The master drives activations, loads and out_ready; the slave is the layer.
interface bnn_layer_seq_if #(
  parameter int N_IN  = 8,
  parameter int N_OUT = 4,
  parameter int CHUNK = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [N_IN-1:0]   in_data;
  logic              load_en;
  logic              load_sel;
  logic [CHUNK-1:0]  load_data;
  logic              out_valid;
  logic              out_ready;
  logic [N_OUT-1:0]  out_data;
  logic              busy;

  modport master (
    output in_valid, in_data, load_en, load_sel, load_data, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, load_en, load_sel, load_data, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/bnn_xnor_popcount.sv
// Combinational XNOR-popcount: number of bit positions where x and w agree.
// Zero latency, no flow control.
module bnn_xnor_popcount
  import bnn_pkg::*;
#(
  parameter int N_IN = 8
) (
  input  logic [N_IN-1:0]        x,
  input  logic [N_IN-1:0]        w,
  output logic [cnt_w(N_IN)-1:0] cnt
);
  localparam int CNT_W = cnt_w(N_IN);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < N_IN; i++) begin
      cnt = cnt + CNT_W'(x[i] ~^ w[i]);
    end
  end
endmodule

// File: rtl/bnn_layer_seq.sv
// Binary NN layer evaluating one neuron per cycle; result valid N_OUT cycles after accept.
// Result is held in HOLD until out_ready; no new input or load is taken until then.
module bnn_layer_seq
  import bnn_pkg::*;
#(
  parameter int N_IN    = 8,
  parameter int N_OUT   = 4,
  parameter int CHUNK   = 4,
  parameter int DEF_THR = N_IN / 2
) (
  input  logic clk,
  input  logic reset,
  bnn_layer_seq_if.slave bus
);
  localparam int CNT_W = cnt_w(N_IN);
  localparam int N_CH  = N_IN / CHUNK;
  localparam int N_WCH = N_OUT * N_CH;
  localparam int WP_W  = ptr_w(N_WCH);
  localparam int NP_W  = ptr_w(N_OUT);

  state_e             state_q, state_d;
  logic [N_IN-1:0]    w_q   [N_OUT];
  logic [N_IN-1:0]    w_d   [N_OUT];
  logic [CNT_W-1:0]   thr_q [N_OUT];
  logic [CNT_W-1:0]   thr_d [N_OUT];
  logic [N_IN-1:0]    x_q, x_d;
  logic [N_OUT-1:0]   out_q, out_d;
  logic [WP_W-1:0]    wptr_q, wptr_d;
  logic [NP_W-1:0]    tptr_q, tptr_d;
  logic [NP_W-1:0]    nidx_q, nidx_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   match_cnt;
  logic               load_ok, in_fire, hit;

  bnn_xnor_popcount #(.N_IN(N_IN)) u_popcount (
    .x   (x_q),
    .w   (w_q[nidx_q]),
    .cnt (match_cnt)
  );

  // A pending load takes priority over a new input in the same cycle.
  assign bus.in_ready  = (state_q == IDLE) && !bus.load_en && !reset;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_q;
  assign bus.busy      = busy_q;

  assign load_ok = (state_q == IDLE) && bus.load_en;
  assign in_fire = bus.in_valid && bus.in_ready;
  assign hit     = (match_cnt >= thr_q[nidx_q]);

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    thr_d   = thr_q;
    x_d     = x_q;
    out_d   = out_q;
    wptr_d  = wptr_q;
    tptr_d  = tptr_q;
    nidx_d  = nidx_q;

    if (load_ok && bus.load_sel == LD_WEIGHT) begin
      for (int n = 0; n < N_OUT; n++) begin
        for (int c = 0; c < N_CH; c++) begin
          if (wptr_q == WP_W'(n * N_CH + c)) w_d[n][c*CHUNK +: CHUNK] = bus.load_data;
        end
      end
      wptr_d = (wptr_q == WP_W'(N_WCH - 1)) ? '0 : wptr_q + WP_W'(1);
    end

    if (load_ok && bus.load_sel == LD_THR) begin
      for (int n = 0; n < N_OUT; n++) begin
        if (tptr_q == NP_W'(n)) thr_d[n] = bus.load_data[CNT_W-1:0];
      end
      tptr_d = (tptr_q == NP_W'(N_OUT - 1)) ? '0 : tptr_q + NP_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (in_fire) begin
          x_d     = bus.in_data;
          nidx_d  = '0;
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        out_d[nidx_q] = hit;
        if (nidx_q == NP_W'(N_OUT - 1)) begin
          nidx_d  = '0;
          state_d = HOLD;
        end else begin
          nidx_d = nidx_q + NP_W'(1);
        end
      end
      HOLD: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    out_valid_d = (state_d == HOLD);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      for (int n = 0; n < N_OUT; n++) begin
        w_q[n]   <= '0;
        thr_q[n] <= CNT_W'(DEF_THR);
      end
      x_q         <= '0;
      out_q       <= '0;
      wptr_q      <= '0;
      tptr_q      <= '0;
      nidx_q      <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      w_q         <= w_d;
      thr_q       <= thr_d;
      x_q         <= x_d;
      out_q       <= out_d;
      wptr_q      <= wptr_d;
      tptr_q      <= tptr_d;
      nidx_q      <= nidx_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end
endmodule
